// File: rtl/bus_pkg.sv
// Shared bus definitions: initiator state encoding, control-bus bit map and default widths.
package bus_pkg;

  localparam int unsigned DEFAULT_BUS_WIDTH  = 32;
  localparam int unsigned DEFAULT_CTRL_WIDTH = 8;
  localparam int unsigned CTRL_WE_BIT        = 1;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StAddr,
    StWait,
    StData,
    StDone
  } bus_state_e;

  // Slaves see a transaction for as long as ack is high: ADDR, WAIT and DATA.
  function automatic logic state_drives_ack(bus_state_e s);
    return (s == StAddr) || (s == StWait) || (s == StData);
  endfunction

endpackage

// File: rtl/bus_grant_timer.sv
// Counts consecutive grant-wait cycles; flags the last cycle before the wait limit is reached.
module bus_grant_timer #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic expired
);

  localparam int unsigned Width = ($clog2(LIMIT + 1) < 8) ? 8 : $clog2(LIMIT + 1);

  logic [Width-1:0] count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (run) begin
      count_q <= count_q + 1'b1;
    end else begin
      count_q <= '0;
    end
  end

  // count_q holds the number of earlier wait cycles, so this fires in wait cycle LIMIT.
  assign expired = run && (count_q == Width'(LIMIT - 1));

endmodule

// File: rtl/bus_master_interface.sv
// Shared-bus initiator: one read/write per command, arbitration, then the addr/data/ack sequence.
// Optional grant-wait timeout abort is enabled by defining BUS_MASTER_TIMEOUT_EN.
module bus_master_interface
  import bus_pkg::*;
#(
  parameter int unsigned BUS_WIDTH      = DEFAULT_BUS_WIDTH,
  parameter int unsigned CTRL_WIDTH     = DEFAULT_CTRL_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  we,
  input  logic [BUS_WIDTH-1:0]  addr,
  input  logic [BUS_WIDTH-1:0]  wdata,
  output logic [BUS_WIDTH-1:0]  rdata,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic                  bus_req,
  input  logic                  bus_grant,
  output logic [BUS_WIDTH-1:0]  bus_out,
  output logic                  bus_oe,
  input  logic [BUS_WIDTH-1:0]  bus_in,
  output logic [CTRL_WIDTH-1:0] ctrl_out,
  output logic                  ack
);

  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be nonzero");
  end

  bus_state_e           state_q, state_d;
  logic                 we_q, we_d;
  logic [BUS_WIDTH-1:0] addr_q, addr_d;
  logic [BUS_WIDTH-1:0] wdata_q, wdata_d;
  logic                 timeout_hit;

  logic                  busy_d, done_d, error_d, bus_req_d, bus_oe_d, ack_d;
  logic [BUS_WIDTH-1:0]  bus_out_d, rdata_d;
  logic [CTRL_WIDTH-1:0] ctrl_d;

`ifdef BUS_MASTER_TIMEOUT_EN
  bus_grant_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_grant_timer (
    .clk     (clk),
    .rst     (rst),
    .run     (state_q == StReq),
    .expired (timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
      bus_req  <= 1'b0;
      bus_out  <= '0;
      bus_oe   <= 1'b0;
      ctrl_out <= '0;
      ack      <= 1'b0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata    <= rdata_d;
      busy     <= busy_d;
      done     <= done_d;
      error    <= error_d;
      bus_req  <= bus_req_d;
      bus_out  <= bus_out_d;
      bus_oe   <= bus_oe_d;
      ctrl_out <= ctrl_d;
      ack      <= ack_d;
    end
  end

  // Outputs are decoded from the next state so the registered copies line up with state_q.
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StReq;
          we_d    = we;
          addr_d  = addr;
          wdata_d = wdata;
        end
      end
      StReq: begin
        if (bus_grant) begin
          state_d = StAddr;
        end else if (timeout_hit) begin
          state_d = StIdle;
        end
      end
      StAddr:  state_d = StWait;
      StWait:  state_d = StData;
      StData:  state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    busy_d    = (state_d != StIdle);
    bus_req_d = (state_d == StReq) || state_drives_ack(state_d);
    ack_d     = state_drives_ack(state_d);
    done_d    = (state_d == StDone);
    error_d   = (state_q == StReq) && (state_d == StIdle);

    bus_oe_d  = 1'b0;
    bus_out_d = '0;
    if ((state_d == StAddr) || (state_d == StWait)) begin
      bus_oe_d  = 1'b1;
      bus_out_d = addr_d;
    end else if ((state_d == StData) && we_d) begin
      bus_oe_d  = 1'b1;
      bus_out_d = wdata_d;
    end

    ctrl_d = '0;
    if (ack_d) begin
      ctrl_d[CTRL_WE_BIT] = we_d;
    end

    rdata_d = ((state_q == StData) && !we_q) ? bus_in : rdata;
  end

endmodule
